lcd_time_writer: RTL and testbench
==================================

LCD_TIME_WRITER -- requirements
Module: lcd_time_writer

Interface
REQ-001 Parameter E_HIGH_CYCLES, default 4, clocks lcd_e is held high per write (legal range 1..255).
REQ-002 Parameter GAP_CYCLES, default 40, clocks lcd_e is held low after each write before the next write starts (legal range 1..255).
REQ-003 Parameter ADDR_CMD, default 8'h80, DDRAM set-address command byte sent before the characters.
REQ-004 Port clk, input, 1, sole clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1, one clock; reset is synchronous and active-low.
REQ-006 Port start, input, 1, one-cycle request to write the current time to the LCD.
REQ-007 Port hour, input, 5, hours value (0..23 nominal).
REQ-008 Port minute, input, 6, minutes value (0..59 nominal).
REQ-009 Port second, input, 6, seconds value (0..59 nominal).
REQ-010 Port lcd_e, output, 1, LCD enable strobe.
REQ-011 Port lcd_rs, output, 1, LCD register select (0 = command, 1 = data).
REQ-012 Port lcd_rw, output, 1, LCD read/write; constant 0.
REQ-013 Port lcd_data, output, 8, LCD data bus.
REQ-014 Port busy, output, 1, high while a transfer is in progress.
REQ-015 Port done, output, 1, one-cycle pulse when a transfer completes.

Function
REQ-016 The block SHALL implement FSM states IDLE, LOAD, SETUP, E_HIGH, GAP and DONE.
REQ-017 In IDLE, start=1 SHALL move the FSM to LOAD and snapshot hour, minute and second into internal registers; later input changes SHALL NOT affect the transfer in progress.
REQ-018 During snapshot, any field value above 59 SHALL be clamped to 59 (hour is not clamped to 23).
REQ-019 The block SHALL perform 9 writes, indexed 0..8: index 0 = ADDR_CMD with RS=0; indices 1..8 = H10, H1, ':', M10, M1, ':', S10, S1 with RS=1.
REQ-020 Digits SHALL be encoded as ASCII 0x30..0x39, and ':' SHALL be 0x3A.
REQ-021 Every write SHALL take 1 SETUP cycle (data and RS valid, E=0), then E_HIGH_CYCLES cycles with E=1, then GAP_CYCLES cycles with E=0.
REQ-022 lcd_data and lcd_rs SHALL remain stable from SETUP through the end of GAP for each write.
REQ-023 After the GAP of index 8, the FSM SHALL enter DONE, assert done for exactly 1 cycle, then return to IDLE.
REQ-024 busy SHALL be 1 from the cycle after start is accepted through the DONE cycle inclusive, and 0 otherwise.
REQ-025 The start-to-done latency SHALL be 1 (LOAD) + 9 x (1 + E_HIGH_CYCLES + GAP_CYCLES) cycles; with defaults this is 406 cycles.
REQ-026 start SHALL be ignored outside IDLE, with no queuing; a start in the DONE cycle SHALL also be ignored.
REQ-027 The cycle counter and the index counter SHALL be wide enough for the parameter range, and SHALL NOT wrap within a transfer.
REQ-028 In IDLE, lcd_e SHALL be 0 and lcd_data and lcd_rs SHALL hold their last values.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force the following on the next edge, regardless of state, including mid-pulse: state=IDLE, lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, busy=0, done=0, and counters and snapshot registers to 0.
REQ-030 A start sampled while rst_n=0 SHALL be discarded.

Structure
REQ-031 The FSM state encodings, the ASCII_COLON and ASCII_ZERO constants, and the write count (9) SHALL live in the shared clock package.
REQ-032 The block SHALL use exactly one instance of num_to_two_char, time-multiplexed by field select (hour, minute or second) and driven from the snapshot registers; the block SHALL NOT contain any other conversion logic.

Verification
REQ-033 Scenario: 12:34:56 with start -> bytes 80(RS0), 31, 32, 3A, 33, 34, 3A, 35, 36 (RS1); E high 4 cycles each; done at cycle 406.
REQ-034 Scenario: 00:00:00 -> bytes 30 30 3A 30 30 3A 30 30; 23:59:59 -> bytes 32 33 3A 35 39 3A 35 39.
REQ-035 Scenario: minute=63 and second=60 -> bytes "59" for minutes and "59" for seconds; changing hour mid-transfer leaves the bytes already being sent unchanged.
REQ-036 Scenario: start re-pulsed at cycles 10 and 405 -> exactly one transfer and one done pulse.
REQ-037 Scenario: rst_n low during E_HIGH of index 4 -> next edge lcd_e=0, busy=0, data=00; a fresh start then gives a full 9-byte sequence.

Source files
------------

// File: rtl/lcd_time_writer_pkg.sv
// Shared definitions for the LCD time writer.
// Holds the FSM state and field-select encodings, the ASCII constants used
// to build characters, the number of LCD writes per transfer, counter widths
// and the snapshot clamp helper.
package lcd_time_writer_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StSetup = 3'd2,
        StEHigh = 3'd3,
        StGap   = 3'd4,
        StDone  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FieldHour   = 2'd0,
        FieldMinute = 2'd1,
        FieldSecond = 2'd2
    } field_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;

    // Address command plus "HH:MM:SS".
    localparam int unsigned NUM_WRITES = 9;

    // Cycle counter covers the 1..255 parameter range; index covers 0..8.
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = 4;

    function automatic logic [5:0] clamp59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

endpackage

// File: rtl/lcd_time_writer_if.sv
// Request/LCD bundle for the LCD time writer.
// Request side: start, hour, minute, second.
// LCD side: lcd_e, lcd_rs, lcd_rw, lcd_data; status: busy, done.
// master = requester/observer, slave = the writer itself.
interface lcd_time_writer_if;

    logic       start;
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       busy;
    logic       done;

    modport master (
        output start, hour, minute, second,
        input  lcd_e, lcd_rs, lcd_rw, lcd_data, busy, done
    );

    modport slave (
        input  start, hour, minute, second,
        output lcd_e, lcd_rs, lcd_rw, lcd_data, busy, done
    );

endinterface

// File: rtl/num_to_two_char.sv
// Converts a 0..63 binary value into two ASCII decimal digits.
// Ports: value (6-bit binary), tens_char / ones_char (ASCII digits).
// Purely combinational; uses a subtract chain instead of a divider.
module num_to_two_char
    import lcd_time_writer_pkg::*;
(
    input  logic [5:0] value,
    output logic [7:0] tens_char,
    output logic [7:0] ones_char
);

    logic [3:0] tens;
    logic [5:0] rem;

    always_comb begin
        tens = 4'd0;
        rem  = value;
        if (value >= 6'd60) begin
            tens = 4'd6;
            rem  = value - 6'd60;
        end else if (value >= 6'd50) begin
            tens = 4'd5;
            rem  = value - 6'd50;
        end else if (value >= 6'd40) begin
            tens = 4'd4;
            rem  = value - 6'd40;
        end else if (value >= 6'd30) begin
            tens = 4'd3;
            rem  = value - 6'd30;
        end else if (value >= 6'd20) begin
            tens = 4'd2;
            rem  = value - 6'd20;
        end else if (value >= 6'd10) begin
            tens = 4'd1;
            rem  = value - 6'd10;
        end
    end

    assign tens_char = ASCII_ZERO + {4'd0, tens};
    assign ones_char = ASCII_ZERO + {2'd0, rem};

endmodule

// File: rtl/lcd_time_writer.sv
// Writes the current time to a character LCD as "HH:MM:SS".
// On start (in idle) the time is snapshotted (minute/second clamped to 59),
// then a DDRAM address command and eight characters are written, each as
// SETUP (1 cycle), E high (E_HIGH_CYCLES), E low gap (GAP_CYCLES).
// Ports: clk, rst_n (synchronous, active-low), bus (slave modport):
//   start/hour/minute/second in; lcd_e/lcd_rs/lcd_rw/lcd_data, busy, done out.
// All outputs are registered.
module lcd_time_writer
    import lcd_time_writer_pkg::*;
#(
    parameter int unsigned E_HIGH_CYCLES = 4,
    parameter int unsigned GAP_CYCLES    = 40,
    parameter logic [7:0]  ADDR_CMD      = 8'h80
) (
    input logic              clk,
    input logic              rst_n,
    lcd_time_writer_if.slave bus
);

    localparam logic [CNT_W-1:0] E_LAST   = CNT_W'(E_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WRITES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4:0]         hour_q, hour_d;
    logic [5:0]         minute_q, minute_d;
    logic [5:0]         second_q, second_d;
    logic [7:0]         data_q, data_d;
    logic               rs_q, rs_d;
    logic               e_q, e_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    field_t             fsel;
    logic [5:0]         conv_value;
    logic [7:0]         tens_char;
    logic [7:0]         ones_char;
    logic [7:0]         byte_sel;

    // Single shared converter; the field is chosen by the index about to be
    // presented, so the character is ready when SETUP is entered.
    always_comb begin
        fsel = FieldHour;
        case (idx_d)
            4'd4, 4'd5: fsel = FieldMinute;
            4'd7, 4'd8: fsel = FieldSecond;
            default:    fsel = FieldHour;
        endcase
    end

    always_comb begin
        conv_value = 6'd0;
        unique case (fsel)
            FieldHour:   conv_value = {1'b0, hour_q};
            FieldMinute: conv_value = minute_q;
            FieldSecond: conv_value = second_q;
            default:     conv_value = 6'd0;
        endcase
    end

    num_to_two_char u_conv (
        .value     (conv_value),
        .tens_char (tens_char),
        .ones_char (ones_char)
    );

    always_comb begin
        byte_sel = 8'h00;
        case (idx_d)
            4'd0:             byte_sel = ADDR_CMD;
            4'd1, 4'd4, 4'd7: byte_sel = tens_char;
            4'd2, 4'd5, 4'd8: byte_sel = ones_char;
            4'd3, 4'd6:       byte_sel = ASCII_COLON;
            default:          byte_sel = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        hour_d   = hour_q;
        minute_d = minute_q;
        second_d = second_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StLoad;
                    hour_d   = bus.hour;
                    minute_d = clamp59(bus.minute);
                    second_d = clamp59(bus.second);
                    idx_d    = '0;
                    cnt_d    = '0;
                end
            end
            StLoad: begin
                state_d = StSetup;
            end
            StSetup: begin
                state_d = StEHigh;
                cnt_d   = '0;
            end
            StEHigh: begin
                if (cnt_q == E_LAST) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StSetup;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        e_d    = (state_d == StEHigh);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);

        // SETUP lasts one cycle, so entering it is the only load point;
        // data and RS then hold through E high, the gap and idle.
        data_d = data_q;
        rs_d   = rs_q;
        if (state_d == StSetup) begin
            data_d = byte_sel;
            rs_d   = (idx_d != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= '0;
            hour_q   <= '0;
            minute_q <= '0;
            second_q <= '0;
            data_q   <= '0;
            rs_q     <= 1'b0;
            e_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            second_q <= second_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            e_q      <= e_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.lcd_e    = e_q;
    assign bus.lcd_rs   = rs_q;
    assign bus.lcd_rw   = 1'b0;
    assign bus.lcd_data = data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_lcd_time_writer.sv
// Directed bench for lcd_time_writer with default timing (E=4, gap=40).
// Cycle 0 is the observation right after the edge that samples start.
module tb_lcd_time_writer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    lcd_time_writer_if bus ();

    lcd_time_writer #(
        .E_HIGH_CYCLES (4),
        .GAP_CYCLES    (40),
        .ADDR_CMD      (8'h80)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] got_data [9];
    logic [8:0] got_rs;
    int n_wr, done_cyc, done_cnt, e_bad, stab_bad, busy_cnt;
    logic busy_after;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        bus.hour   = h;
        bus.minute = m;
        bus.second = s;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    // Observes one transfer; optionally pulses start at up to three cycles
    // and changes hour at one cycle.
    task automatic watch(input int pa, input int pb, input int pc,
                         input int hour_at, input logic [4:0] hour_new);
        logic       prev_e;
        logic [7:0] prev_data;
        logic       prev_rs;
        logic       pend;
        logic       chg;
        int         e_len;
        prev_e     = bus.lcd_e;
        prev_data  = bus.lcd_data;
        prev_rs    = bus.lcd_rs;
        pend       = 1'b0;
        e_len      = 0;
        n_wr       = 0;
        done_cyc   = -1;
        done_cnt   = 0;
        e_bad      = 0;
        stab_bad   = 0;
        busy_cnt   = 0;
        busy_after = 1'bx;
        got_rs     = '0;
        for (int c = 1; c <= 600; c++) begin
            tick();
            if (bus.lcd_e && !prev_e) begin
                if (n_wr < 9) begin
                    got_data[n_wr] = bus.lcd_data;
                    got_rs[n_wr]   = bus.lcd_rs;
                end
                n_wr++;
                e_len = 0;
            end
            if (bus.lcd_e) e_len++;
            if (!bus.lcd_e && prev_e && e_len != 4) e_bad++;
            // A data/RS change must be a SETUP: E low now, E rising next cycle.
            chg = bus.busy && (bus.lcd_data !== prev_data || bus.lcd_rs !== prev_rs);
            if (pend && !(bus.lcd_e && !prev_e)) stab_bad++;
            if (chg && bus.lcd_e) stab_bad++;
            pend = chg;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (done_cyc > 0 && c == done_cyc + 1) busy_after = bus.busy;
            prev_e    = bus.lcd_e;
            prev_data = bus.lcd_data;
            prev_rs   = bus.lcd_rs;
            bus.start = (c == pa) || (c == pb) || (c == pc);
            if (c == hour_at) bus.hour = hour_new;
            if (done_cyc > 0 && c >= done_cyc + 10) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [71:0] exp);
        check({tag, " writes"}, n_wr, 9);
        check({tag, " done_cycle"}, done_cyc, 406);
        check({tag, " done_pulses"}, done_cnt, 1);
        check({tag, " e_width"}, e_bad, 0);
        check({tag, " stable"}, stab_bad, 0);
        check({tag, " busy_cycles"}, busy_cnt, 406);
        check({tag, " busy_after_done"}, {31'd0, busy_after}, 0);
        check({tag, " rs"}, {23'd0, got_rs}, 32'h1FE);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s byte%0d", tag, i), {24'd0, got_data[i]}, {24'd0, exp[71-8*i -: 8]});
        end
    endtask

    initial begin
        bus.start  = 1'b1;
        bus.hour   = 5'd12;
        bus.minute = 6'd34;
        bus.second = 6'd56;

        // Reset with start held high: start must be discarded.
        repeat (3) tick();
        check("rst lcd_e", {31'd0, bus.lcd_e}, 0);
        check("rst lcd_rs", {31'd0, bus.lcd_rs}, 0);
        check("rst lcd_rw", {31'd0, bus.lcd_rw}, 0);
        check("rst lcd_data", {24'd0, bus.lcd_data}, 0);
        check("rst busy", {31'd0, bus.busy}, 0);
        check("rst done", {31'd0, bus.done}, 0);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        tick();
        tick();
        check("post-rst idle busy", {31'd0, bus.busy}, 0);

        // 12:34:56
        do_start(5'd12, 6'd34, 6'd56);
        check("t1 busy at load", {31'd0, bus.busy}, 1);
        check("t1 e at load", {31'd0, bus.lcd_e}, 0);
        watch(-1, -1, -1, -1, 5'd0);
        verify("t1", {8'h80, 8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36});
        check("idle hold data", {24'd0, bus.lcd_data}, 32'h36);
        check("idle hold rs", {31'd0, bus.lcd_rs}, 1);
        check("idle e", {31'd0, bus.lcd_e}, 0);

        // 00:00:00
        do_start(5'd0, 6'd0, 6'd0);
        watch(-1, -1, -1, -1, 5'd0);
        verify("t0", {8'h80, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h30});

        // 23:59:59 with start re-pulsed mid-transfer, late gap and DONE cycle.
        do_start(5'd23, 6'd59, 6'd59);
        watch(10, 405, 406, -1, 5'd0);
        verify("t23", {8'h80, 8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39});
        check("t23 idle after repulse", {31'd0, bus.busy}, 0);

        // Clamp minute/second; hour changes while H10 is on the bus.
        do_start(5'd12, 6'd63, 6'd60);
        watch(-1, -1, -1, 60, 5'd7);
        verify("clamp", {8'h80, 8'h31, 8'h32, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39});

        // Reset during E high of index 4 (M10 of 12:34:56).
        do_start(5'd12, 6'd34, 6'd56);
        repeat (182) tick();
        check("mid e high", {31'd0, bus.lcd_e}, 1);
        check("mid data", {24'd0, bus.lcd_data}, 32'h33);
        rst_n = 1'b0;
        tick();
        check("midrst e", {31'd0, bus.lcd_e}, 0);
        check("midrst busy", {31'd0, bus.busy}, 0);
        check("midrst data", {24'd0, bus.lcd_data}, 0);
        check("midrst rs", {31'd0, bus.lcd_rs}, 0);
        check("midrst done", {31'd0, bus.done}, 0);
        rst_n = 1'b1;
        tick();
        check("midrst idle", {31'd0, bus.busy}, 0);
        do_start(5'd23, 6'd59, 6'd59);
        watch(-1, -1, -1, -1, 5'd0);
        verify("after_rst", {8'h80, 8'h32, 8'h33, 8'h3A, 8'h35, 8'h39, 8'h3A, 8'h35, 8'h39});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
